// File: rtl/ef_match_reporter.sv
// ef_match_reporter: turns each valid upstream match count into a delta vs. the last count, queues it in a FWFT FIFO.
// Latency: a sample written at edge N is at the head right after edge N (one registered stage, no comb bypass).
// Backpressure: out_valid/out_ready on the drain side; upstream has none, so a full FIFO drops and counts samples.
// Optional feature: define EF_REPORT_SKIP_ZERO_EN to discard zero deltas before the FIFO.
module ef_match_reporter #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int THRESH = 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   valid_in,
   input  logic [DATA_W-1:0]      count_in,
   input  logic                   alarm_clr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [$clog2(DEPTH):0] level,
   output logic [15:0]            drop_count,
   output logic                   alarm
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0]     FULL_LVL = LW'(DEPTH);
   localparam logic [DATA_W-1:0] THRESH_V = DATA_W'(THRESH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [15:0]       drop_q, drop_d;
   logic              alarm_q, alarm_d;
   logic [DATA_W-1:0] last_q, last_d;

   logic [DATA_W-1:0] delta;
   logic              skip;
   logic              full;
   logic              rd_en;
   logic              wr_en;
   logic              drop_en;

   // Delta is modulo 2^DATA_W so a counter wrap reads as a small forward step.
   assign delta = count_in - last_q;

`ifdef EF_REPORT_SKIP_ZERO_EN
   // Zero deltas carry no information; they never reach the FIFO, drop counter or alarm.
   assign skip = (delta == '0);
`else
   assign skip = 1'b0;
`endif

   assign full    = (level_q == FULL_LVL);
   assign rd_en   = (level_q != '0) && out_ready;
   // A full FIFO still accepts a sample when the head leaves on the same edge.
   assign wr_en   = valid_in && !skip && (!full || rd_en);
   assign drop_en = valid_in && !skip && full && !rd_en;

   assign out_valid  = (level_q != '0);
   assign out_data   = mem_q[rd_ptr_q];
   assign level      = level_q;
   assign drop_count = drop_q;
   assign alarm      = alarm_q;

   // Next-state for pointers, occupancy, drop counter, alarm and last-seen count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      drop_d   = drop_q;
      alarm_d  = alarm_q;
      last_d   = last_q;

      if (valid_in) begin
         last_d = count_in;
      end
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      if (drop_en && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end
      // Set has priority over a same-cycle clear.
      if (wr_en && (delta >= THRESH_V)) begin
         alarm_d = 1'b1;
      end else if (alarm_clr) begin
         alarm_d = 1'b0;
      end
   end

   // Control state register; reset discards FIFO contents and ignores same-cycle traffic.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         drop_q   <= '0;
         alarm_q  <= 1'b0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         drop_q   <= drop_d;
         alarm_q  <= alarm_d;
         last_q   <= last_d;
      end
   end

   // FIFO storage needs no reset; entries are only visible once written.
   always_ff @(posedge i_clk) begin
      if (!i_reset && wr_en) begin
         mem_q[wr_ptr_q] <= delta;
      end
   end

endmodule

// File: tb/tb_ef_match_reporter.sv
// tb_ef_match_reporter: directed scenarios plus randomized traffic against a queue-based reference model.
// Latency: outputs sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: out_ready is driven by the bench, both held and randomized.
module tb_ef_match_reporter;

   localparam int DEPTH  = 4;
   localparam int THRESH = 8;
`ifdef EF_REPORT_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        valid_in = 1'b0;
   logic [31:0] count_in = '0;
   logic        alarm_clr = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [2:0]  level;
   logic [15:0] drop_count;
   logic        alarm;

   int n_pass = 0;
   int n_total = 0;

   // Reference model state
   logic [31:0] m_q[$];
   logic [31:0] m_last = '0;
   int          m_drops = 0;
   logic        m_alarm = 1'b0;

   ef_match_reporter #(.DATA_W(32), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .valid_in(valid_in), .count_in(count_in),
      .alarm_clr(alarm_clr), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .level(level), .drop_count(drop_count), .alarm(alarm)
   );

   always #5 i_clk = ~i_clk;

   // Model one clock edge from the pre-edge model state and the applied inputs.
   task automatic model_step(input logic rst, input logic v, input logic [31:0] c,
                             input logic r, input logic clr);
      logic [31:0] d;
      bit rd, wr, set;
      if (rst) begin
         m_q.delete();
         m_last = '0;
         m_drops = 0;
         m_alarm = 1'b0;
         return;
      end
      rd = (m_q.size() != 0) && r;
      wr = 0;
      set = 0;
      d = c - m_last;
      if (v) begin
         m_last = c;
         if (!(SKIP && d == 0)) begin
            if (m_q.size() < DEPTH || rd) begin
               wr = 1;
               set = (d >= THRESH);
            end else if (m_drops < 65535) begin
               m_drops++;
            end
         end
      end
      if (rd) void'(m_q.pop_front());
      if (wr) m_q.push_back(d);
      if (set) m_alarm = 1'b1;
      else if (clr) m_alarm = 1'b0;
   endtask

   task automatic drive(input logic rst, input logic v, input logic [31:0] c,
                        input logic r, input logic clr);
      i_reset = rst; valid_in = v; count_in = c; out_ready = r; alarm_clr = clr;
      model_step(rst, v, c, r, clr);
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic test_reset();
      logic [31:0] exp_d [4];
      exp_d = '{32'd0, 32'd1, 32'd1, 32'd1};
      drive(1, 1, 32'h55, 1, 0);
      drive(1, 1, 32'h77, 1, 0);
      n_total++;
      if ({out_valid, level, drop_count, alarm} !== 21'd0)
         $display("FAIL reset_state: got v=%0b lvl=%0d drop=%0d alarm=%0b required all zero",
                  out_valid, level, drop_count, alarm);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, i, 1, 0);
         n_total++;
         if (out_valid !== 1'b1 || out_data !== exp_d[i] || level > 3'd1)
            $display("FAIL reset_seq[%0d]: got v=%0b data=%0d lvl=%0d required v=1 data=%0d lvl<=1",
                     i, out_valid, out_data, level, exp_d[i]);
         else n_pass++;
      end
      drive(0, 0, 0, 1, 0);
      n_total++;
      if (level !== 3'd0 || out_valid !== 1'b0 || drop_count !== 16'd0)
         $display("FAIL reset_drain: got lvl=%0d v=%0b drop=%0d required 0/0/0", level, out_valid, drop_count);
      else n_pass++;
   endtask

   task automatic test_overflow();
      logic [31:0] c = 0;
      drive(1, 0, 0, 0, 0);
      for (int i = 1; i <= 6; i++) begin
         c = c + i;
         drive(0, 1, c, 0, 0);
      end
      n_total++;
      if (level !== 3'd4 || drop_count !== 16'd2 || out_valid !== 1'b1)
         $display("FAIL overflow_fill: got lvl=%0d drop=%0d v=%0b required 4/2/1", level, drop_count, out_valid);
      else n_pass++;
      for (int i = 1; i <= 4; i++) begin
         n_total++;
         if (out_valid !== 1'b1 || out_data !== 32'(i))
            $display("FAIL overflow_drain[%0d]: got v=%0b data=%0d required v=1 data=%0d", i, out_valid, out_data, i);
         else n_pass++;
         drive(0, 0, c, 1, 0);
      end
      n_total++;
      if (level !== 3'd0 || out_valid !== 1'b0)
         $display("FAIL overflow_empty: got lvl=%0d v=%0b required 0/0", level, out_valid);
      else n_pass++;
   endtask

   task automatic test_full_simul();
      logic [31:0] c = 0;
      drive(1, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         c = c + i;
         drive(0, 1, c, 0, 0);
      end
      c = c + 5;
      drive(0, 1, c, 1, 0);
      n_total++;
      if (level !== 3'd4 || drop_count !== 16'd0 || out_data !== 32'd2)
         $display("FAIL full_simul: got lvl=%0d drop=%0d head=%0d required 4/0/2", level, drop_count, out_data);
      else n_pass++;
      for (int i = 2; i <= 5; i++) begin
         n_total++;
         if (out_data !== 32'(i))
            $display("FAIL full_simul_drain[%0d]: got %0d required %0d", i, out_data, i);
         else n_pass++;
         drive(0, 0, c, 1, 0);
      end
   endtask

   task automatic test_wrap();
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 32'hFFFF_FFFE, 1, 0);
      drive(0, 1, 32'h0000_0001, 1, 1);
      n_total++;
      if (out_data !== 32'd3 || alarm !== 1'b0 || level !== 3'd1)
         $display("FAIL wrap: got data=%0h alarm=%0b lvl=%0d required 3/0/1", out_data, alarm, level);
      else n_pass++;
      drive(0, 0, 0, 1, 0);
   endtask

   task automatic test_alarm();
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 32'd10, 1, 0);
      n_total++;
      if (alarm !== 1'b1) $display("FAIL alarm_set: got %0b required 1", alarm);
      else n_pass++;
      drive(0, 1, 32'd22, 1, 1);
      n_total++;
      if (alarm !== 1'b1) $display("FAIL alarm_set_wins: got %0b required 1", alarm);
      else n_pass++;
      drive(0, 0, 32'd22, 1, 1);
      n_total++;
      if (alarm !== 1'b0) $display("FAIL alarm_clr: got %0b required 0", alarm);
      else n_pass++;
      // Fill with small steps, then a big jump that is dropped: no alarm.
      for (int i = 23; i <= 26; i++) drive(0, 1, i, 0, 0);
      drive(0, 1, 32'd100, 0, 0);
      n_total++;
      if (alarm !== 1'b0 || drop_count !== 16'd1)
         $display("FAIL alarm_drop: got alarm=%0b drop=%0d required 0/1", alarm, drop_count);
      else n_pass++;
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0);
   endtask

   task automatic test_zero_skip();
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 32'd5, 0, 0);
         n_total++;
         if (level !== (SKIP ? 3'd1 : 3'(i + 1)))
            $display("FAIL zero_level[%0d]: got %0d required %0d", i, level, SKIP ? 1 : i + 1);
         else n_pass++;
      end
      for (int i = 0; i < (SKIP ? 1 : 4); i++) begin
         n_total++;
         if (out_valid !== 1'b1 || out_data !== (i == 0 ? 32'd5 : 32'd0))
            $display("FAIL zero_entry[%0d]: got v=%0b data=%0d required v=1 data=%0d",
                     i, out_valid, out_data, i == 0 ? 5 : 0);
         else n_pass++;
         drive(0, 0, 0, 1, 0);
      end
      n_total++;
      if (out_valid !== 1'b0 || drop_count !== 16'd0)
         $display("FAIL zero_end: got v=%0b drop=%0d required 0/0", out_valid, drop_count);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] c;
      logic v, r, clr, rst;
      drive(1, 0, 0, 0, 0);
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) == 0);
         clr = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 9))
            0:       c = $urandom;
            1, 2:    c = m_last;
            default: c = m_last + $urandom_range(0, 12);
         endcase
         drive(rst, v, c, r, clr);
         n_total++;
         if (out_valid !== (m_q.size() != 0) || level !== 3'(m_q.size()) ||
             drop_count !== 16'(m_drops) || alarm !== m_alarm ||
             (m_q.size() != 0 && out_data !== m_q[0]))
            $display("FAIL random[%0d]: got v=%0b lvl=%0d drop=%0d alarm=%0b data=%0h required v=%0b lvl=%0d drop=%0d alarm=%0b data=%0h",
                     n, out_valid, level, drop_count, alarm, out_data,
                     m_q.size() != 0, m_q.size(), m_drops, m_alarm,
                     m_q.size() != 0 ? m_q[0] : 32'h0);
         else n_pass++;
      end
   endtask

   initial begin
      @(negedge i_clk);
      test_reset();
      test_overflow();
      test_full_simul();
      test_wrap();
      test_alarm();
      test_zero_skip();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
